prime_query_scheduler: RTL and testbench

Shares one prime-check engine among `NREQ` requesters. Each requester submits an 11-bit candidate over a valid/ready handshake. The scheduler grants requesters round-robin and sequences the engine through a start/done handshake. It returns a tagged prime/not-prime response and keeps running statistics. It sits between the exercise's stimulus sources and the prime-check datapath, and is the only block that drives the engine.

---
 rtl/prime_query_scheduler.sv | 98 +++++++++
 tb/tb_prime_query_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prime_query_scheduler.sv
// Round-robin arbiter that shares one prime-check engine among NREQ requesters,
// sequences the engine start/done handshake and returns tagged responses with statistics.
module prime_query_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 11,
   parameter int IDW   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_num,
   output logic [NREQ-1:0]       req_ready,
   output logic                  eng_start,
   output logic [WIDTH-1:0]      eng_num,
   input  logic                  eng_done,
   input  logic                  eng_prime,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_num,
   output logic                  rsp_prime,
   output logic [WIDTH-1:0]      prime_count,
   output logic [WIDTH-1:0]      served_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state, state_nx;
   logic [IDW-1:0]   rr_ptr, cur_id, gnt_id;
   logic [WIDTH-1:0] cur_num, gnt_num;
   logic             cur_prime, gnt_any;

   // first valid requester at or above rr_ptr, wrapping modulo NREQ
   always_comb begin
      int k;
      gnt_any = 1'b0;
      gnt_id  = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = (int'(rr_ptr) + i) % NREQ;
         if (!gnt_any && req_valid[k]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(k);
         end
      end
      gnt_num = req_num[int'(gnt_id)*WIDTH +: WIDTH];
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      case (state)
         IDLE: if (gnt_any && !rst) begin
            req_ready[gnt_id] = 1'b1;
            state_nx = (gnt_num < WIDTH'(2)) ? RESP : ISSUE;
         end
         ISSUE: state_nx = WAIT;
         WAIT:  if (eng_done) state_nx = RESP;
         RESP:  if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         cur_id       <= '0;
         cur_num      <= '0;
         cur_prime    <= 1'b0;
         prime_count  <= '0;
         served_count <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (gnt_any) begin
               cur_id    <= gnt_id;
               cur_num   <= gnt_num;
               cur_prime <= 1'b0;
            end
            WAIT: if (eng_done) cur_prime <= eng_prime;
            RESP: if (rsp_ready) begin
               if (served_count != '1) served_count <= served_count + 1'b1;
               if (cur_prime && prime_count != '1) prime_count <= prime_count + 1'b1;
               rr_ptr <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign eng_start = (state == ISSUE);
   assign eng_num   = cur_num;
   assign rsp_valid = (state == RESP);
   assign rsp_id    = cur_id;
   assign rsp_num   = cur_num;
   assign rsp_prime = cur_prime;

endmodule

// File: tb/tb_prime_query_scheduler.sv
// Directed bench for prime_query_scheduler with a behavioural engine answering after lat cycles.
module tb_prime_query_scheduler;
   localparam int NREQ = 4, W = 11, IDW = 3;

   logic              clk = 1'b0, rst = 1'b1;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_num = '0;
   logic [NREQ-1:0]   req_ready;
   logic              eng_start, eng_done, eng_prime;
   logic [W-1:0]      eng_num, rsp_num, prime_count, served_count;
   logic              rsp_valid, rsp_prime;
   logic              rsp_ready = 1'b0;
   logic [IDW-1:0]    rsp_id;

   logic eng_done_a = 1'b0, eng_prime_a = 1'b0, eng_done_m = 1'b0, eng_prime_m = 1'b0;
   logic eng_auto = 1'b0;
   int   lat = 1;
   int   nvec = 0, nerr = 0, n, ng, nr;
   logic [NREQ-1:0] g [5];
   logic            rp [4];

   assign eng_done  = eng_done_a | eng_done_m;
   assign eng_prime = eng_prime_a | eng_prime_m;

   prime_query_scheduler #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
      .eng_start(eng_start), .eng_num(eng_num), .eng_done(eng_done), .eng_prime(eng_prime),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_num(rsp_num),
      .rsp_prime(rsp_prime), .prime_count(prime_count), .served_count(served_count));

   always #5 clk = ~clk;

   function automatic logic is_prime(input logic [W-1:0] v);
      if (v < 2) return 1'b0;
      for (int d = 2; d * d <= int'(v); d++)
         if (int'(v) % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   // engine model: done pulse lat cycles after the start cycle
   always @(negedge clk) begin
      if (eng_auto && eng_start) begin
         repeat (lat) @(negedge clk);
         eng_done_a  = 1'b1;
         eng_prime_a = is_prime(eng_num);
         @(negedge clk);
         eng_done_a  = 1'b0;
         eng_prime_a = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; eng_done_m = 1'b0; eng_prime_m = 1'b0;
      repeat (2) step;
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      // reset with every requester valid
      rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
      req_num = {11'd13, 11'd12, 11'd11, 11'd10};
      for (int i = 0; i < 3; i++) begin
         step;
         chk("reset_out", {req_ready, eng_start, eng_num, rsp_valid, rsp_id, rsp_prime}, 0);
         chk("reset_cnt", {rsp_num, prime_count, served_count}, 0);
      end
      rst = 1'b0; req_valid = '0;

      // single request, L=3
      do_reset;
      eng_auto = 1'b1; lat = 3; rsp_ready = 1'b1;
      req_num[2*W +: W] = 11'd997; req_valid = 4'b0100;
      #1 chk("grant1", req_ready, 4'b0100);
      step; req_valid = '0; n = 1;
      chk("start1", {eng_start, eng_num}, {1'b1, 11'd997});
      while (!rsp_valid && n < 20) begin step; n++; end
      chk("lat1", n, 5);
      chk("rsp1", {rsp_id, rsp_num, rsp_prime}, {3'd2, 11'd997, 1'b1});
      step;
      chk("cnt1", {rsp_valid, prime_count, served_count}, {1'b0, 11'd1, 11'd1});

      // round robin, all valid, L=1
      do_reset;
      lat = 1; rsp_ready = 1'b1; req_valid = '1;
      req_num = {11'd13, 11'd12, 11'd11, 11'd10};
      ng = 0; nr = 0; n = 0;
      while (ng < 5 && n < 200) begin
         #1;
         if (req_ready != 0) begin g[ng] = req_ready; ng++; end
         if (rsp_valid && rsp_ready) begin if (nr < 4) rp[nr] = rsp_prime; nr++; end
         if (ng == 5) chk("rr_cnt", {prime_count, served_count}, {11'd2, 11'd4});
         step; n++;
      end
      chk("rr_ngrant", ng, 5);
      for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), g[i], 1 << (i % 4));
      for (int i = 0; i < 4; i++) chk($sformatf("rr_prime%0d", i), rp[i], i % 2);
      req_valid = '0;
      repeat (8) step;

      // bypass with backpressure
      do_reset;
      req_num[W +: W] = 11'd1; req_valid = 4'b0010; rsp_ready = 1'b0;
      #1 chk("grant_byp", req_ready, 4'b0010);
      step; req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         chk("byp_hold", {rsp_valid, rsp_id, rsp_num, rsp_prime, eng_start},
             {1'b1, 3'd1, 11'd1, 1'b0, 1'b0});
         if (i < 4) step;
      end
      rsp_ready = 1'b1;
      step;
      chk("byp_done", {rsp_valid, served_count, prime_count}, {1'b0, 11'd1, 11'd0});

      // spurious done in IDLE, then reset while in WAIT
      do_reset;
      eng_auto = 1'b0; eng_done_m = 1'b1; eng_prime_m = 1'b1;
      step;
      eng_done_m = 1'b0; eng_prime_m = 1'b0;
      chk("spur", {rsp_valid, eng_start, prime_count, served_count}, 0);
      req_num[3*W +: W] = 11'd7; req_valid = 4'b1000; rsp_ready = 1'b1;
      #1 chk("grant3", req_ready, 4'b1000);
      step; req_valid = '0;
      chk("start3", {eng_start, eng_num}, {1'b1, 11'd7});
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("mid_rst_a", {rsp_valid, eng_start, eng_num, rsp_num}, 0);
      chk("mid_rst_b", {rsp_id, prime_count, served_count}, 0);
      eng_done_m = 1'b1; eng_prime_m = 1'b1;
      step;
      eng_done_m = 1'b0; eng_prime_m = 1'b0;
      step;
      chk("late_done", {rsp_valid, eng_start, served_count}, 0);

      // counter saturation
      do_reset;
      eng_auto = 1'b1; lat = 1; rsp_ready = 1'b1;
      req_num[0 +: W] = 11'd2; req_valid = 4'b0001;
      nr = 0; n = 0;
      while (nr < 2048 && n < 20000) begin
         if (rsp_valid && rsp_ready) begin
            nr++;
            step; n++;
            if (nr == 2047) chk("sat_2047", prime_count, 2047);
            if (nr == 2048) chk("sat_hold", {prime_count, served_count}, {11'd2047, 11'd2047});
         end else begin
            step; n++;
         end
      end
      chk("sat_nrsp", nr, 2048);
      req_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not reach its summary in time");
      $fatal(1);
   end

endmodule
